preg_free_list: RTL and testbench

//  Circular free list of physical registers feeding the rename stage's alloc_p_reg.

---
 rtl/preg_free_list_if.sv | 45 ++++
 rtl/preg_free_list.sv | 161 ++++++++++++++++
 tb/tb_preg_free_list.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/preg_free_list_if.sv
// preg_free_list_if
//   Bus between the rename/commit logic and the physical register free list.
//   master : rename/commit side. It drives pop/push requests, checkpoint and
//            recovery controls, and sees the offered pregs and the list status.
//   slave  : preg_free_list.
//   Signals:
//     pop_en[INSTR_COUNT], pop_preg[INSTR_COUNT][PW], pop_ready
//     push_en[INSTR_COUNT], push_preg[INSTR_COUNT][PW]
//     ckpt_take, ckpt_id[CW], rec_en, rec_ckpt_id[CW]
//     free_count[NW+1], empty, full, err_dup
interface preg_free_list_if #(
    parameter int P_REGISTERS = 64,
    parameter int L_REGISTERS = 32,
    parameter int INSTR_COUNT = 2,
    parameter int C_NUM       = 4
);
    localparam int PW = $clog2(P_REGISTERS);
    localparam int CW = $clog2(C_NUM);
    localparam int N  = P_REGISTERS - L_REGISTERS;
    localparam int NW = $clog2(N);

    logic [INSTR_COUNT-1:0]         pop_en;
    logic [INSTR_COUNT-1:0][PW-1:0] pop_preg;
    logic                           pop_ready;
    logic [INSTR_COUNT-1:0]         push_en;
    logic [INSTR_COUNT-1:0][PW-1:0] push_preg;
    logic                           ckpt_take;
    logic [CW-1:0]                  ckpt_id;
    logic                           rec_en;
    logic [CW-1:0]                  rec_ckpt_id;
    logic [NW:0]                    free_count;
    logic                           empty;
    logic                           full;
    logic                           err_dup;

    modport master (
        output pop_en, push_en, push_preg, ckpt_take, ckpt_id, rec_en, rec_ckpt_id,
        input  pop_preg, pop_ready, free_count, empty, full, err_dup
    );

    modport slave (
        input  pop_en, push_en, push_preg, ckpt_take, ckpt_id, rec_en, rec_ckpt_id,
        output pop_preg, pop_ready, free_count, empty, full, err_dup
    );
endinterface

// File: rtl/preg_free_list.sv
// preg_free_list
//   Circular free list of physical registers for the rename stage. Offers up
//   to INSTR_COUNT pregs per cycle, takes back up to INSTR_COUNT released
//   pregs per cycle from commit, and holds C_NUM head-pointer checkpoints so a
//   flush restores the list in a single cycle.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : preg_free_list_if.slave (pop/push, checkpoint/recovery, status)
//   Optional feature (macro PREG_FREE_LIST_DUP_CHECK_EN):
//     Tracks which pregs are in the list. A push of a preg that is already
//     free is dropped and raises the sticky err_dup flag. Without the macro,
//     err_dup is tied low and every push is accepted.
//   The list depth N = P_REGISTERS - L_REGISTERS must be a power of two.
module preg_free_list #(
    parameter int P_REGISTERS = 64,
    parameter int L_REGISTERS = 32,
    parameter int INSTR_COUNT = 2,
    parameter int C_NUM       = 4
) (
    input logic             clk,
    input logic             rst,
    preg_free_list_if.slave bus
);
    localparam int N  = P_REGISTERS - L_REGISTERS;
    localparam int PW = $clog2(P_REGISTERS);
    localparam int NW = $clog2(N);

    // Pointers carry an extra wrap bit so that full and empty are distinct.
    typedef logic [NW:0] ptr_t;

    logic [PW-1:0] mem     [N];
    logic [PW-1:0] mem_nxt [N];
    ptr_t          head, head_nxt;
    ptr_t          tail, tail_nxt;
    ptr_t          ckpt    [C_NUM];
    ptr_t          free_count;
    ptr_t          pop_cnt;
    logic [NW-1:0] pop_idx [INSTR_COUNT];
    logic          pop_ready;
    logic          pop_fire;
    logic          push_ok;

    assign free_count     = tail - head;
    assign pop_ready      = free_count >= ptr_t'(INSTR_COUNT);
    assign pop_fire       = pop_ready && (|bus.pop_en) && !bus.rec_en;
    assign bus.free_count = free_count;
    assign bus.pop_ready  = pop_ready;
    assign bus.empty      = (free_count == '0);
    assign bus.full       = (free_count == ptr_t'(N));

    // Enabled slots take consecutive entries starting at head.
    always_comb begin : pop_offer
        pop_cnt = '0;
        for (int unsigned i = 0; i < INSTR_COUNT; i++) begin
            pop_idx[i]      = head[NW-1:0] + pop_cnt[NW-1:0];
            bus.pop_preg[i] = mem[pop_idx[i]];
            if (bus.pop_en[i]) begin
                pop_cnt = pop_cnt + 1'b1;
            end
        end
    end

`ifdef PREG_FREE_LIST_DUP_CHECK_EN
    logic [P_REGISTERS-1:0] in_list, in_list_nxt;
    logic                   push_dup;
    logic                   err_dup;
    logic [NW-1:0]          rec_idx;
    assign bus.err_dup = err_dup;
`else
    assign bus.err_dup = 1'b0;
`endif

    always_comb begin : next_state
        mem_nxt  = mem;
        tail_nxt = tail;
        push_ok  = 1'b0;
`ifdef PREG_FREE_LIST_DUP_CHECK_EN
        in_list_nxt = in_list;
        push_dup    = 1'b0;
        rec_idx     = '0;
        // Pops clear first, so a preg popped and released in the same cycle
        // is not mistaken for a duplicate.
        if (pop_fire) begin
            for (int unsigned i = 0; i < INSTR_COUNT; i++) begin
                if (bus.pop_en[i]) begin
                    in_list_nxt[bus.pop_preg[i]] = 1'b0;
                end
            end
        end
`endif
        for (int unsigned i = 0; i < INSTR_COUNT; i++) begin
            push_ok = bus.push_en[i];
`ifdef PREG_FREE_LIST_DUP_CHECK_EN
            if (push_ok && in_list_nxt[bus.push_preg[i]]) begin
                push_ok  = 1'b0;
                push_dup = 1'b1;
            end
`endif
            if (push_ok) begin
                mem_nxt[tail_nxt[NW-1:0]] = bus.push_preg[i];
                tail_nxt                  = tail_nxt + 1'b1;
`ifdef PREG_FREE_LIST_DUP_CHECK_EN
                in_list_nxt[bus.push_preg[i]] = 1'b1;
`endif
            end
        end

        head_nxt = head;
        if (bus.rec_en) begin
            head_nxt = ckpt[bus.rec_ckpt_id];
        end else if (pop_fire) begin
            head_nxt = head + pop_cnt;
        end

`ifdef PREG_FREE_LIST_DUP_CHECK_EN
        // After a restore the free set is exactly the window [head', tail').
        if (bus.rec_en) begin
            in_list_nxt = '0;
            for (int unsigned k = 0; k < N; k++) begin
                rec_idx = head_nxt[NW-1:0] + NW'(k);
                if (ptr_t'(k) < ptr_t'(tail_nxt - head_nxt)) begin
                    in_list_nxt[mem_nxt[rec_idx]] = 1'b1;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= ptr_t'(N);
            for (int unsigned k = 0; k < N; k++) begin
                mem[k] <= PW'(L_REGISTERS + k);
            end
            for (int unsigned c = 0; c < C_NUM; c++) begin
                ckpt[c] <= '0;
            end
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
            mem  <= mem_nxt;
            if (bus.ckpt_take && !bus.rec_en) begin
                ckpt[bus.ckpt_id] <= head_nxt;
            end
        end
    end

`ifdef PREG_FREE_LIST_DUP_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_list <= {{N{1'b1}}, {L_REGISTERS{1'b0}}};
            err_dup <= 1'b0;
        end else begin
            in_list <= in_list_nxt;
            err_dup <= err_dup | push_dup;
        end
    end
`endif
endmodule

// File: tb/tb_preg_free_list.sv
// tb_preg_free_list
//   Directed scenarios plus randomized legal traffic for preg_free_list,
//   checked against a reference model that keeps the free list as an
//   unbounded sequence indexed by absolute position, with per-preg state.
module tb_preg_free_list;
    localparam int P  = 64;
    localparam int L  = 32;
    localparam int IC = 2;
    localparam int CN = 4;
    localparam int N  = P - L;
    localparam int PW = $clog2(P);
    localparam int CW = $clog2(CN);
`ifdef PREG_FREE_LIST_DUP_CHECK_EN
    localparam bit DUP_CHK = 1'b1;
`else
    localparam bit DUP_CHK = 1'b0;
`endif

    logic clk;
    logic rst;

    preg_free_list_if #(.P_REGISTERS(P), .L_REGISTERS(L), .INSTR_COUNT(IC), .C_NUM(CN)) bus ();

    preg_free_list #(.P_REGISTERS(P), .L_REGISTERS(L), .INSTR_COUNT(IC), .C_NUM(CN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_checks;
    int unsigned n_pass;

    // Reference model: mq[abs] holds the preg written at absolute position abs.
    // pop_pos[p]: -2 free (in list), -1 allocated before any tracked pop,
    // >=0 absolute position it was popped from.
    int mq [int];
    int head_abs;
    int tail_abs;
    int ck   [CN];
    bit ck_v [CN];
    int pop_pos [P];
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive_idle();
        bus.pop_en      = '0;
        bus.push_en     = '0;
        bus.push_preg   = '0;
        bus.ckpt_take   = 1'b0;
        bus.ckpt_id     = '0;
        bus.rec_en      = 1'b0;
        bus.rec_ckpt_id = '0;
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < N; i++) mq[i] = L + i;
        head_abs = 0;
        tail_abs = N;
        for (int c = 0; c < CN; c++) begin
            ck[c]   = 0;
            ck_v[c] = 1'b0;
        end
        for (int p = 0; p < P; p++) pop_pos[p] = (p < L) ? -1 : -2;
        m_err = 1'b0;
    endtask

    task automatic model_update(input logic [IC-1:0] pe, input logic [IC-1:0] ue,
                                input int u0, input int u1, input logic ct, input int cid,
                                input logic re, input int rid);
        int  u [IC];
        int  fc;
        bit  fire;
        int  h;
        u[0] = u0;
        u[1] = u1;
        fc   = tail_abs - head_abs;
        if (fc + $countones(ue) > N) $display("WARNING: push overflow in stimulus");
        fire = (fc >= IC) && (pe != '0) && !re;
        if (fire) begin
            for (int i = 0; i < IC; i++) begin
                if (pe[i]) begin
                    pop_pos[mq[head_abs]] = head_abs;
                    head_abs++;
                end
            end
        end
        for (int i = 0; i < IC; i++) begin
            if (ue[i]) begin
                if (DUP_CHK && pop_pos[u[i]] == -2) begin
                    m_err = 1'b1;
                end else begin
                    mq[tail_abs] = u[i];
                    tail_abs++;
                    pop_pos[u[i]] = -2;
                end
            end
        end
        if (ct && !re) begin
            ck[cid]   = head_abs;
            ck_v[cid] = 1'b1;
        end
        if (re) begin
            h = ck[rid];
            for (int p = 0; p < P; p++) if (pop_pos[p] >= h) pop_pos[p] = -2;
            head_abs = h;
            for (int c = 0; c < CN; c++) if (ck_v[c] && ck[c] > h) ck_v[c] = 1'b0;
        end
    endtask

    task automatic check_outputs(input logic [IC-1:0] pe);
        int fc;
        int off;
        int pos;
        fc  = tail_abs - head_abs;
        off = 0;
        check("free_count", 32'(bus.free_count), fc);
        check("empty", 32'(bus.empty), (fc == 0) ? 1 : 0);
        check("full", 32'(bus.full), (fc == N) ? 1 : 0);
        check("pop_ready", 32'(bus.pop_ready), (fc >= IC) ? 1 : 0);
        check("err_dup", 32'(bus.err_dup), m_err ? 1 : 0);
        for (int i = 0; i < IC; i++) begin
            pos = head_abs + off;
            if (pos < tail_abs) check($sformatf("pop_preg[%0d]", i), 32'(bus.pop_preg[i]), mq[pos]);
            if (pe[i]) off++;
        end
    endtask

    // One clock cycle: drive at negedge, check, then advance the model at posedge.
    task automatic step(input logic [IC-1:0] pe, input logic [IC-1:0] ue, input int u0, input int u1,
                        input logic ct, input int cid, input logic re, input int rid);
        @(negedge clk);
        bus.pop_en       = pe;
        bus.push_en      = ue;
        bus.push_preg[0] = PW'(u0);
        bus.push_preg[1] = PW'(u1);
        bus.ckpt_take    = ct;
        bus.ckpt_id      = CW'(cid);
        bus.rec_en       = re;
        bus.rec_ckpt_id  = CW'(rid);
        #1;
        check_outputs(pe);
        @(posedge clk);
        model_update(pe, ue, u0, u1, ct, cid, re, rid);
    endtask

    task automatic pop_only(input logic [IC-1:0] pe);
        step(pe, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    // Reset is raised mid-cycle to exercise the asynchronous path.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        drive_idle();
        #1;
        model_reset();
        check("rst_free_count", 32'(bus.free_count), N);
        check("rst_full", 32'(bus.full), 1);
        check("rst_empty", 32'(bus.empty), 0);
        check("rst_pop_ready", 32'(bus.pop_ready), 1);
        check("rst_err_dup", 32'(bus.err_dup), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Legal random traffic: pushes only release pregs that are not inside
    // any live checkpoint window, and never exceed list capacity.
    task automatic rand_step();
        logic [IC-1:0] pe;
        logic [IC-1:0] ue;
        int   u [IC];
        int   minck;
        int   limit;
        int   nu;
        int   idx;
        int   cand [$];
        logic ct;
        int   cid;
        logic re;
        int   rid;
        pe = IC'($urandom_range(0, 3));
        for (int c = 0; c < CN; c++) if (ck_v[c] && $urandom_range(0, 7) == 0) ck_v[c] = 1'b0;
        minck = head_abs;
        for (int c = 0; c < CN; c++) if (ck_v[c] && ck[c] < minck) minck = ck[c];
        limit = N - (tail_abs - minck);
        for (int p = 0; p < P; p++) begin
            if (pop_pos[p] == -1 || (pop_pos[p] >= 0 && pop_pos[p] < minck)) cand.push_back(p);
        end
        nu = int'($urandom_range(0, 2));
        if (nu > limit) nu = limit;
        if (nu > cand.size()) nu = cand.size();
        u[0] = int'($urandom_range(0, P - 1));
        u[1] = int'($urandom_range(0, P - 1));
        ue   = '0;
        for (int k = 0; k < nu; k++) begin
            idx = int'($urandom_range(0, cand.size() - 1));
            if (nu == 2) begin
                u[k]  = cand[idx];
                ue[k] = 1'b1;
            end else begin
                int s;
                s     = int'($urandom_range(0, 1));
                u[s]  = cand[idx];
                ue[s] = 1'b1;
            end
            cand.delete(idx);
        end
        ct  = ($urandom_range(0, 5) == 0);
        cid = int'($urandom_range(0, CN - 1));
        rid = int'($urandom_range(0, CN - 1));
        re  = ck_v[rid] && ($urandom_range(0, 9) == 0);
        step(pe, ue, u[0], u[1], ct, cid, re, rid);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        drive_idle();
        model_reset();
        do_reset();

        // Reset release: two pregs offered in order.
        bus.pop_en = 2'b11;
        #1;
        check("t1_pop_preg0", 32'(bus.pop_preg[0]), 32);
        check("t1_pop_preg1", 32'(bus.pop_preg[1]), 33);
        bus.pop_en = 2'b00;

        // Drain in pairs, then an ignored pop when empty.
        for (int k = 0; k < 16; k++) pop_only(2'b11);
        #1;
        check("t2_empty", 32'(bus.empty), 1);
        check("t2_pop_ready", 32'(bus.pop_ready), 0);
        pop_only(2'b11);
        #1;
        check("t2_count_after_17th", 32'(bus.free_count), 0);

        // Only the upper slot enabled.
        do_reset();
        pop_only(2'b10);
        #1;
        check("t3_count", 32'(bus.free_count), 31);
        check("t3_next_preg", 32'(bus.pop_preg[0]), 33);

        // Checkpoint on third pop, four more pops, restore.
        do_reset();
        pop_only(2'b01);
        pop_only(2'b01);
        step(2'b01, 2'b00, 0, 0, 1'b1, 1, 1'b0, 0);
        for (int k = 0; k < 4; k++) pop_only(2'b01);
        step(2'b00, 2'b00, 0, 0, 1'b0, 0, 1'b1, 1);
        #1;
        check("t4_pop_preg0", 32'(bus.pop_preg[0]), 35);
        check("t4_count", 32'(bus.free_count), 29);

        // Pop refused below pop_ready while pushes still land; push+pop together.
        do_reset();
        for (int k = 0; k < 15; k++) pop_only(2'b11);
        pop_only(2'b01);
        step(2'b11, 2'b11, 5, 6, 1'b0, 0, 1'b0, 0);
        #1;
        check("t5_count3", 32'(bus.free_count), 3);
        pop_only(2'b01);
        step(2'b11, 2'b01, 7, 0, 1'b0, 0, 1'b0, 0);
        #1;
        check("t5_count1", 32'(bus.free_count), 1);
        check("t5_next_preg", 32'(bus.pop_preg[0]), 7);

`ifdef PREG_FREE_LIST_DUP_CHECK_EN
        // Duplicate release of a free preg.
        do_reset();
        step(2'b00, 2'b01, 40, 0, 1'b0, 0, 1'b0, 0);
        #1;
        check("t6_err_dup", 32'(bus.err_dup), 1);
        check("t6_count", 32'(bus.free_count), 32);
        do_reset();
`endif

        // Randomized legal traffic with a reset in the middle.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            rand_step();
        end
        @(negedge clk);
        drive_idle();
        #1;
        check_outputs(2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
